// File: rtl/ysyx_23060096_regfile_mp_if.sv
// Decode/writeback-side bundle of the multi-port GPR file: write, issue, read and ready.
// master = core pipeline side, slave = register file.
interface ysyx_23060096_regfile_mp_if #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_RD     = 2
);
   logic                           ready;
   logic                           w_en;
   logic [ADDR_WIDTH-1:0]          waddr;
   logic [DATA_WIDTH-1:0]          wdata;
   logic                           issue_en;
   logic [ADDR_WIDTH-1:0]          issue_addr;
   logic [NUM_RD*ADDR_WIDTH-1:0]   raddr;
   logic [NUM_RD*DATA_WIDTH-1:0]   rdata;
   logic [NUM_RD-1:0]              rbusy;

   modport master (
      input  ready, rdata, rbusy,
      output w_en, waddr, wdata, issue_en, issue_addr, raddr
   );

   modport slave (
      output ready, rdata, rbusy,
      input  w_en, waddr, wdata, issue_en, issue_addr, raddr
   );
endinterface

// File: rtl/ysyx_23060096_regfile_mp.sv
// Multi-read-port GPR file with sequential post-reset clear and pending-write scoreboard.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writeback data/busy to the read ports.
module ysyx_23060096_regfile_mp #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_RD     = 2,
   parameter int unsigned ZERO_REG   = 1
) (
   input  logic clk,
   input  logic rst,
   ysyx_23060096_regfile_mp_if.slave bus
);
   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic {INIT, RUN} state_t;

   state_t                  state, state_nxt;
   logic [ADDR_WIDTH-1:0]   clr_cnt;
   logic [DATA_WIDTH-1:0]   rf [DEPTH];
   logic [DEPTH-1:0]        busy, busy_nxt;
   logic                    run;
   logic                    wr_en;
   logic [ADDR_WIDTH-1:0]   wr_addr;
   logic [DATA_WIDTH-1:0]   wr_data;

   always_ff @(posedge clk) begin
      if (rst) state <= INIT;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (state == INIT && clr_cnt == '1) state_nxt = RUN;
   end

   always_comb begin
      run       = (state == RUN);
      bus.ready = run;
   end

   always_ff @(posedge clk) begin
      if (rst)                clr_cnt <= '0;
      else if (state == INIT) clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
   end

   // Single storage write port shared by the clear sweep and writeback.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      if (!rst) begin
         if (!run) begin
            wr_en   = 1'b1;
            wr_addr = clr_cnt;
         end else if (bus.w_en && !(ZERO_REG != 0 && bus.waddr == '0)) begin
            wr_en   = 1'b1;
            wr_addr = bus.waddr;
            wr_data = bus.wdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) rf[wr_addr] <= wr_data;
   end

   // Set after clear so a new producer supersedes the one completing this cycle.
   always_comb begin
      busy_nxt = busy;
      if (run) begin
         if (bus.w_en)     busy_nxt[bus.waddr]      = 1'b0;
         if (bus.issue_en) busy_nxt[bus.issue_addr] = 1'b1;
      end
      if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) busy <= '0;
      else     busy <= busy_nxt;
   end

   always_comb begin
      logic [ADDR_WIDTH-1:0] ra;
      logic [DATA_WIDTH-1:0] rd;
      logic                  rb;
      logic                  is_zero;
      ra        = '0;
      rd        = '0;
      rb        = 1'b0;
      is_zero   = 1'b0;
      bus.rdata = '0;
      bus.rbusy = '0;
      for (int unsigned p = 0; p < NUM_RD; p++) begin
         ra      = bus.raddr[p*ADDR_WIDTH +: ADDR_WIDTH];
         is_zero = (ZERO_REG != 0) && (ra == '0);
         rd      = rf[ra];
         rb      = busy[ra];
`ifdef REGFILE_BYPASS_EN
         if (bus.w_en && bus.waddr == ra) begin
            rd = bus.wdata;
            rb = bus.issue_en && (bus.issue_addr == ra);
         end
`endif
         if (is_zero || !run) begin
            rd = '0;
            rb = 1'b0;
         end
         bus.rdata[p*DATA_WIDTH +: DATA_WIDTH] = rd;
         bus.rbusy[p]                          = rb;
      end
   end
endmodule

// File: tb/tb_ysyx_23060096_regfile_mp.sv
// Directed self-checking bench for ysyx_23060096_regfile_mp (default 32x32, 2 read ports, x0 hardwired).
module tb_ysyx_23060096_regfile_mp;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   ysyx_23060096_regfile_mp_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_RD(2)) bus ();

   ysyx_23060096_regfile_mp #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_RD(2), .ZERO_REG(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        ie;
      logic [4:0]  ia;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [31:0] ed0;
      logic [31:0] ed1;
      logic        eb0;
      logic        eb1;
   } vec_t;

   vec_t vecs [16];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic ie, input logic [4:0] ia, input logic [4:0] ra0, input logic [4:0] ra1);
      bus.w_en       = we;
      bus.waddr      = wa;
      bus.wdata      = wd;
      bus.issue_en   = ie;
      bus.issue_addr = ia;
      bus.raddr      = {ra1, ra0};
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      // x5/x7/x4/x31 traffic; reads are sampled before the edge that commits the row's write.
      vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  5'd1,  5'd2,  32'h0,        32'h0,        1'b0, 1'b0};
      vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 5'd0,  32'h1234,     1'b1, 5'd0,  5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0};
      vecs[4]  = '{1'b1, 5'd7,  32'h11,       1'b1, 5'd7,  5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
      vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd7,  32'h11,       32'h11,       1'b1, 1'b1};
      vecs[6]  = '{1'b1, 5'd7,  32'h22,       1'b0, 5'd0,  5'd5,  5'd1,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
      vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd31, 32'h22,       32'h0,        1'b0, 1'b0};
      vecs[8]  = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd4,  5'd1,  5'd2,  32'h0,        32'h0,        1'b0, 1'b0};
      vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd31, 5'd4,  32'hFFFFFFFF, 32'h0,        1'b0, 1'b1};
      vecs[10] = '{1'b1, 5'd4,  32'h44,       1'b1, 5'd31, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0};
      vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd4,  5'd31, 32'h44,       32'hFFFFFFFF, 1'b0, 1'b1};
      vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 5'd1,  5'd1,  32'h0,        32'h0,        1'b0, 1'b0};
      vecs[13] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd31, 5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1};
      vecs[14] = '{1'b1, 5'd31, 32'h0,        1'b0, 5'd0,  5'd4,  5'd4,  32'h44,       32'h44,       1'b0, 1'b0};
      vecs[15] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd31, 5'd4,  32'h0,        32'h44,       1'b0, 1'b0};

      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("init_ready0", {31'b0, bus.ready}, 32'h0);

      // Clear sweep: writes/issues during INIT must be ignored.
      drive(1'b1, 5'd12, 32'hCAFE0001, 1'b1, 5'd12, 5'd12, 5'd3);
      for (int k = 1; k <= 32; k++) begin
         tick();
         if (k == 31 || k == 32)
            chk($sformatf("ready_c%0d", k), {31'b0, bus.ready}, (k == 32) ? 32'h1 : 32'h0);
         else if (bus.ready !== 1'b0)
            chk($sformatf("ready_c%0d", k), {31'b0, bus.ready}, 32'h0);
         if (k == 16) begin
            chk("init_rdata0", bus.rdata[31:0], 32'h0);
            chk("init_rbusy0", {30'b0, bus.rbusy}, 32'h0);
         end
      end
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
      for (int a = 0; a < 32; a += 2) begin
         bus.raddr = {5'(a + 1), 5'(a)};
         #1;
         chk($sformatf("clr_x%0d", a),     bus.rdata[31:0],  32'h0);
         chk($sformatf("clr_x%0d", a + 1), bus.rdata[63:32], 32'h0);
      end
      chk("clr_busy", {30'b0, bus.rbusy}, 32'h0);

      for (int i = 0; i < 16; i++) begin
         drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ie, vecs[i].ia, vecs[i].ra0, vecs[i].ra1);
         #1;
         chk($sformatf("v%0d_rd0", i), bus.rdata[31:0],  vecs[i].ed0);
         chk($sformatf("v%0d_rd1", i), bus.rdata[63:32], vecs[i].ed1);
         chk($sformatf("v%0d_rb0", i), {31'b0, bus.rbusy[0]}, {31'b0, vecs[i].eb0});
         chk($sformatf("v%0d_rb1", i), {31'b0, bus.rbusy[1]}, {31'b0, vecs[i].eb1});
         tick();
      end

      // Same-cycle write/read of x3.
      drive(1'b1, 5'd3, 32'h1111, 1'b0, 5'd0, 5'd3, 5'd3);
      tick();
      drive(1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd3, 5'd3);
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("byp_same", bus.rdata[31:0], 32'hA5A5A5A5);
`else
      chk("byp_same", bus.rdata[31:0], 32'h1111);
`endif
      tick();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3);
      #1;
      chk("byp_next", bus.rdata[63:32], 32'hA5A5A5A5);

      // Mid-RUN reset discards x9 contents and its busy bit.
      drive(1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 5'd9, 5'd5);
      tick();
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd5);
      tick();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd5);
      #1;
      chk("mid_x9", bus.rdata[31:0], 32'h55);
      chk("mid_busy9", {31'b0, bus.rbusy[0]}, 32'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_ready0", {31'b0, bus.ready}, 32'h0);
      chk("mid_rbusy0", {30'b0, bus.rbusy}, 32'h0);
      drive(1'b1, 5'd9, 32'hBAD, 1'b1, 5'd9, 5'd9, 5'd5);
      cnt = 0;
      while (bus.ready !== 1'b1 && cnt < 40) begin
         tick();
         cnt++;
      end
      chk("mid_clr_len", 32'(cnt), 32'd32);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd5);
      #1;
      chk("mid_x9_clr", bus.rdata[31:0], 32'h0);
      chk("mid_x5_clr", bus.rdata[63:32], 32'h0);
      chk("mid_busy9_clr", {31'b0, bus.rbusy[0]}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
